ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage for the 16-bit-instruction core. It sits directly upstream of the instruction decoder. It fetches halfwords from the instruction memory port into a small prefetch queue and presents one instruction per cycle on `ins`/`idone`, which the decoder registers. Branch/jump redirects from execute flush the queue and restart fetch. Memory faults are delivered in-order as the all-zero instruction, which the decoder already treats as a trap.

## Interface
- `RV`, 32, PC/address width.
- `DEPTH`, 4, prefetch queue entries; power of two, ≥2.
- `RESET_PC`, 0, fetch address after reset; bit 0 must be 0.

- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_req`  out  1  fetch request valid.
- `mem_addr`  out  RV  halfword address of request; bit 0 always 0.
- `mem_ack`  in  1  request accepted; `mem_rdata`/`mem_err` valid this same cycle.
- `mem_rdata`  in  16  fetched instruction.
- `mem_err`  in  1  fetch fault for the acked address.
- `redirect`  in  1  one-cycle pulse: discard everything, restart at `redirect_pc`.
- `redirect_pc`  in  RV  new fetch PC; bit 0 ignored (forced 0).
- `stall`  in  1  consumer cannot accept an instruction this cycle.
- `ins`  out  16  head instruction (16'h0000 for a faulted entry).
- `ins_pc`  out  RV  PC of `ins`.
- `ifault`  out  1  head entry is a fetch fault.
- `idone`  out  1  head handed to decoder this cycle.

## Operation
- Registers:
  - `fpc`: next fetch PC.
  - `hpc`: PC of queue head.
  - Queue of {ins[15:0], fault} with rd/wr pointers of log2(DEPTH) bits, wrapping, plus `count` of 0..DEPTH.
  - State `st`: RUN or HALT.
- Request:
  - `mem_req = (st==RUN) && (count<DEPTH) && !redirect`.
  - `mem_addr = fpc`.
  - At most one outstanding request; no later data returns.
  - `mem_addr` is stable while `mem_req` is high without `mem_ack`.
  - Dropping `mem_req` without an ack (redirect or reset only) cancels that request.
- On `mem_ack` (no redirect):
  - Push {mem_err ? 16'h0 : mem_rdata, mem_err}.
  - `fpc += 2`, wrapping mod 2^RV.
  - If `mem_err`, `st` goes to HALT.
- Pop:
  - `idone = (count!=0) && !stall && !redirect`.
  - On `idone`: advance rd pointer, `hpc += 2`.
- Simultaneous push and pop: `count` is unchanged.
- Push is impossible when full because `mem_req` is low.
- Redirect has priority over everything:
  - Queue emptied (count=0, pointers equal).
  - Any same-cycle `mem_ack` data discarded.
  - `fpc` and `hpc` take `{redirect_pc[RV-1:1],1'b0}`.
  - `st` goes to RUN.
- HALT:
  - No requests.
  - The queue drains normally, fault entry included.
  - Only redirect or reset leaves HALT.
- `ins`/`ifault` always show the head slot contents; meaningful only when `count!=0`.

## Timing
- Reset (async assert) values:
  - `count=0`, `st=RUN`, `fpc=hpc=RESET_PC`.
  - All queue slots 0.
  - Outputs: `mem_req=0`, `idone=0`, `ins=0`, `ifault=0`, `ins_pc=RESET_PC`.
- First `mem_req` is in the first cycle after reset deasserts.
- Latency is `mem_ack` cycle N → `idone` possible in cycle N+1 (queue is registered; no bypass).
- Throughput is one instruction/cycle when `mem_ack` is high every cycle and `stall` is low.
- Redirect in cycle N → `mem_req` with the new address in N+1; earliest `idone` in N+2.
- `idone` and `mem_req` are combinational from registered state plus `stall`/`redirect`. There are no other combinational input→output paths.
- Reset mid-request: the request is abandoned; memory must tolerate `mem_req` dropping.

## Structure
- Shared package `ifetch_pkg`:
  - Entry struct {ins, fault}.
  - State enum {RUN, HALT}.
  - `TRAP_INS = 16'h0000`.
- Sub-module `ifetch_fifo`:
  - DEPTH-entry circular buffer with push/pop/flush, `count`, head data.
  - Parameterised on DEPTH and entry type.
- Top level holds `fpc`/`hpc`, the state machine and the request logic.

## Test plan
- **Reset:** RESET_PC=0x100, stall=0, mem_ack every cycle returning 0x1111, 0x2222, … → `mem_addr` 0x100, 0x102, …; `idone` from cycle 2 with `ins_pc` 0x100, 0x102, … in order.
- **Fill:** hold stall=1, ack always → exactly 4 pushes, then `mem_req`=0 with count=4. Release stall → 4 consecutive `idone` and `mem_req` reasserts the cycle after the first pop.
- **Redirect collision:** redirect to 0x2001 in the same cycle as a `mem_ack` with 2 queued → queue empty; the acked data never appears; next `mem_addr`=0x2000; first `ins_pc`=0x2000.
- **Fault:** `mem_err` on the ack for 0x104 → `ins`=0x0000 with `ifault`=1 at `ins_pc`=0x104 after 0x100/0x102. No `mem_req` until a redirect, then fetch resumes in RUN.
- **Wrap:** RV=16, `redirect_pc`=0xFFFE → fetch addresses 0xFFFE then 0x0000; pointers wrap across more than 2×DEPTH pushes with no loss or duplication.
- **Async reset:** assert reset mid-transaction with 3 queued → all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ifetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_pkg : shared types for the instruction fetch stage            |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package ifetch_pkg;

    localparam logic [15:0] TRAP_INS = 16'h0000;

    typedef struct packed {
        logic [15:0] ins;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_fifo : circular prefetch buffer with push/pop/flush           |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module ifetch_fifo #(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = logic [16:0]
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  ENTRY_T                         din,
    output ENTRY_T                         head,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    ENTRY_T            r_mem [DEPTH];
    logic [c_PW-1:0]   r_rd;
    logic [c_PW-1:0]   r_wr;
    logic [c_CW-1:0]   r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr] <= din;
                r_wr        <= r_wr + c_PW'(1);
            end
            if (pop) begin
                r_rd <= r_rd + c_PW'(1);
            end
            if (push && !pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (pop && !push) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

    assign head  = r_mem[r_rd];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch : instruction fetch stage with prefetch queue and redirect    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module ifetch
    import ifetch_pkg::*;
#(
    parameter int            RV       = 32,
    parameter int            DEPTH    = 4,
    parameter logic [RV-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic [RV-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_err,
    input  logic          redirect,
    input  logic [RV-1:0] redirect_pc,
    input  logic          stall,
    output logic [15:0]   ins,
    output logic [RV-1:0] ins_pc,
    output logic          ifault,
    output logic          idone
);

    localparam int c_CW = $clog2(DEPTH + 1);

    fetch_state_t    r_st;
    logic [RV-1:0]   r_fpc;
    logic [RV-1:0]   r_hpc;
    logic [RV-1:0]   w_redirect_pc;
    logic [c_CW-1:0] w_count;
    logic            w_full;
    logic            w_push;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    assign w_full        = (w_count == c_CW'(DEPTH));
    assign w_redirect_pc = redirect_pc & ~RV'(1);

    // Gating on reset keeps the request low while reset is asserted.
    assign mem_req  = !reset && (r_st == RUN) && !w_full && !redirect;
    assign mem_addr = r_fpc;
    assign idone    = (w_count != '0) && !stall && !redirect;
    assign w_push   = mem_req && mem_ack;

    always_comb begin
        w_push_entry.ins   = mem_err ? TRAP_INS : mem_rdata;
        w_push_entry.fault = mem_err;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st  <= RUN;
            r_fpc <= RESET_PC;
            r_hpc <= RESET_PC;
        end else if (redirect) begin
            r_st  <= RUN;
            r_fpc <= w_redirect_pc;
            r_hpc <= w_redirect_pc;
        end else begin
            if (w_push) begin
                r_fpc <= r_fpc + RV'(2);
                if (mem_err) begin
                    r_st <= HALT;
                end
            end
            if (idone) begin
                r_hpc <= r_hpc + RV'(2);
            end
        end
    end

    ifetch_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (idone),
        .flush (redirect),
        .din   (w_push_entry),
        .head  (w_head),
        .count (w_count)
    );

    assign ins    = w_head.ins;
    assign ifault = w_head.fault;
    assign ins_pc = r_hpc;

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ifetch : scoreboard testbench for the ifetch stage                |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module tb_ifetch;

    localparam logic [15:0] c_RESET_PC = 16'h0100;
    localparam logic [15:0] c_XOR      = 16'h5A5A;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ins;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        mem_err;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic [15:0] ins;
    logic [15:0] ins_pc;
    logic        ifault;
    logic        idone;

    logic        ack_en;
    logic        force_ack;
    logic        err_en;
    logic [15:0] err_addr;

    int n_checks = 0;
    int n_errors = 0;

    exp_t        sb[$];
    exp_t        e;
    exp_t        hd;
    logic [15:0] exp_fpc  = c_RESET_PC;
    logic        exp_halt = 1'b0;
    logic        exp_req;
    logic        exp_idone;

    always #10 clk = ~clk;

    // Memory model: returns a value derived from the address, optional fault.
    assign mem_ack   = (ack_en && mem_req) || force_ack;
    assign mem_rdata = mem_addr ^ c_XOR;
    assign mem_err   = mem_ack && err_en && (mem_addr == err_addr);

    ifetch #(
        .RV       (16),
        .DEPTH    (4),
        .RESET_PC (c_RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .ins         (ins),
        .ins_pc      (ins_pc),
        .ifault      (ifault),
        .idone       (idone)
    );

    // Scoreboard: push on accepted request, pop and compare on idone.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            sb.delete();
            exp_fpc  = c_RESET_PC;
            exp_halt = 1'b0;
        end else begin
            exp_req = !exp_halt && (sb.size() < 4) && !redirect;
            n_checks++;
            if (mem_req !== exp_req) begin
                n_errors++;
                $display("FAIL sb_mem_req: got %b expected %b at %0t", mem_req, exp_req, $time);
            end
            if (exp_req) begin
                n_checks++;
                if (mem_addr !== exp_fpc) begin
                    n_errors++;
                    $display("FAIL sb_mem_addr: got %h expected %h at %0t", mem_addr, exp_fpc, $time);
                end
            end
            exp_idone = (sb.size() != 0) && !stall && !redirect;
            n_checks++;
            if (idone !== exp_idone) begin
                n_errors++;
                $display("FAIL sb_idone: got %b expected %b at %0t", idone, exp_idone, $time);
            end
            if (sb.size() != 0) begin
                hd = sb[0];
                n_checks++;
                if (ins_pc !== hd.pc || ins !== hd.ins || ifault !== hd.fault) begin
                    n_errors++;
                    $display("FAIL sb_head: got pc=%h ins=%h f=%b expected pc=%h ins=%h f=%b at %0t",
                             ins_pc, ins, ifault, hd.pc, hd.ins, hd.fault, $time);
                end
            end
            if (redirect) begin
                sb.delete();
                exp_fpc  = redirect_pc & 16'hFFFE;
                exp_halt = 1'b0;
            end else begin
                if (exp_idone) begin
                    hd = sb.pop_front();
                end
                if (exp_req && ack_en) begin
                    e.pc    = exp_fpc;
                    e.fault = err_en && (exp_fpc == err_addr);
                    e.ins   = e.fault ? 16'h0000 : (exp_fpc ^ c_XOR);
                    sb.push_back(e);
                    exp_fpc = exp_fpc + 16'd2;
                    if (e.fault) begin
                        exp_halt = 1'b1;
                    end
                end
            end
        end
    end

    task automatic do_redirect(input logic [15:0] pc);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        redirect    = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (mem_req !== 1'b0 || idone !== 1'b0 || ins !== 16'h0 || ifault !== 1'b0 || ins_pc !== c_RESET_PC) begin
            n_errors++;
            $display("FAIL reset_values: got req=%b done=%b ins=%h f=%b pc=%h expected 0 0 0000 0 %h",
                     mem_req, idone, ins, ifault, ins_pc, c_RESET_PC);
        end
        @(negedge clk);
        reset  = 1'b0;
        ack_en = 1'b1;
        #3;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== c_RESET_PC || idone !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_first_req: got req=%b addr=%h done=%b expected 1 %h 0", mem_req, mem_addr, idone, c_RESET_PC);
        end
        @(negedge clk);
        #3;
        n_checks++;
        if (idone !== 1'b1 || ins_pc !== 16'h0100 || ins !== (16'h0100 ^ c_XOR)) begin
            n_errors++;
            $display("FAIL reset_first_idone: got done=%b pc=%h ins=%h expected 1 0100 %h", idone, ins_pc, ins, 16'h0100 ^ c_XOR);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_fill();
        int pushes;
        int pops;
        do_redirect(16'h0400);
        stall  = 1'b1;
        ack_en = 1'b1;
        pushes = 0;
        for (int i = 0; i < 8; i++) begin
            #3;
            if (mem_req && mem_ack) pushes++;
            @(negedge clk);
        end
        #3;
        n_checks++;
        if (pushes != 4 || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL fill_full: got pushes=%0d req=%b expected 4 0", pushes, mem_req);
        end
        @(negedge clk);
        stall = 1'b0;
        pops  = 0;
        for (int i = 0; i < 4; i++) begin
            #3;
            if (idone) pops++;
            if (i == 0) begin
                n_checks++;
                if (mem_req !== 1'b0) begin
                    n_errors++;
                    $display("FAIL fill_req_first_pop: got %b expected 0", mem_req);
                end
            end
            if (i == 1) begin
                n_checks++;
                if (mem_req !== 1'b1) begin
                    n_errors++;
                    $display("FAIL fill_req_reassert: got %b expected 1", mem_req);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (pops != 4) begin
            n_errors++;
            $display("FAIL fill_drain: got %0d pops expected 4", pops);
        end
    endtask

    task automatic test_redirect_collision();
        do_redirect(16'h0600);
        stall  = 1'b1;
        ack_en = 1'b1;
        #3;
        @(negedge clk);
        #3;
        @(negedge clk);
        ack_en      = 1'b0;
        force_ack   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h2001;
        #3;
        n_checks++;
        if (mem_req !== 1'b0 || idone !== 1'b0) begin
            n_errors++;
            $display("FAIL coll_suppress: got req=%b done=%b expected 0 0", mem_req, idone);
        end
        @(negedge clk);
        redirect  = 1'b0;
        force_ack = 1'b0;
        stall     = 1'b0;
        ack_en    = 1'b1;
        #3;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h2000 || idone !== 1'b0) begin
            n_errors++;
            $display("FAIL coll_restart: got req=%b addr=%h done=%b expected 1 2000 0", mem_req, mem_addr, idone);
        end
        @(negedge clk);
        #3;
        n_checks++;
        if (idone !== 1'b1 || ins_pc !== 16'h2000 || ins !== (16'h2000 ^ c_XOR) || ifault !== 1'b0) begin
            n_errors++;
            $display("FAIL coll_first_ins: got done=%b pc=%h ins=%h f=%b expected 1 2000 %h 0",
                     idone, ins_pc, ins, ifault, 16'h2000 ^ c_XOR);
        end
    endtask

    task automatic test_fault();
        logic seen;
        do_redirect(16'h0100);
        err_en   = 1'b1;
        err_addr = 16'h0104;
        stall    = 1'b0;
        ack_en   = 1'b1;
        seen     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #3;
            if (idone && ifault) begin
                seen = 1'b1;
                n_checks++;
                if (ins_pc !== 16'h0104 || ins !== 16'h0000) begin
                    n_errors++;
                    $display("FAIL fault_entry: got pc=%h ins=%h expected 0104 0000", ins_pc, ins);
                end
            end
            @(negedge clk);
        end
        #3;
        n_checks++;
        if (!seen || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL fault_halt: got seen=%b req=%b expected 1 0", seen, mem_req);
        end
        err_en = 1'b0;
        do_redirect(16'h0300);
        #3;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0300) begin
            n_errors++;
            $display("FAIL fault_resume: got req=%b addr=%h expected 1 0300", mem_req, mem_addr);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wrap();
        int pushes;
        int pops;
        pushes = 0;
        pops   = 0;
        do_redirect(16'hFFFE);
        stall  = 1'b0;
        ack_en = 1'b1;
        #3;
        n_checks++;
        if (mem_addr !== 16'hFFFE) begin
            n_errors++;
            $display("FAIL wrap_addr0: got %h expected fffe", mem_addr);
        end
        if (mem_req && mem_ack) pushes++;
        if (idone) pops++;
        @(negedge clk);
        #3;
        n_checks++;
        if (mem_addr !== 16'h0000) begin
            n_errors++;
            $display("FAIL wrap_addr1: got %h expected 0000", mem_addr);
        end
        if (mem_req && mem_ack) pushes++;
        if (idone) pops++;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            stall  = ($urandom_range(0, 1) == 1);
            ack_en = ($urandom_range(0, 3) != 0);
            #3;
            if (mem_req && mem_ack) pushes++;
            if (idone) pops++;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            stall  = 1'b0;
            ack_en = 1'b0;
            #3;
            if (idone) pops++;
        end
        n_checks++;
        if (pushes <= 8 || pops != pushes) begin
            n_errors++;
            $display("FAIL wrap_count: got pushes=%0d pops=%0d expected >8 and equal", pushes, pops);
        end
    endtask

    task automatic test_async_reset();
        do_redirect(16'h0800);
        stall  = 1'b1;
        ack_en = 1'b1;
        repeat (3) begin
            #3;
            @(negedge clk);
        end
        ack_en = 1'b0;
        stall  = 1'b0;
        #3;
        n_checks++;
        if (mem_req !== 1'b1 || idone !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_pre: got req=%b done=%b expected 1 1", mem_req, idone);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || idone !== 1'b0 || ins !== 16'h0 || ifault !== 1'b0 || ins_pc !== c_RESET_PC) begin
            n_errors++;
            $display("FAIL areset_values: got req=%b done=%b ins=%h f=%b pc=%h expected 0 0 0000 0 %h",
                     mem_req, idone, ins, ifault, ins_pc, c_RESET_PC);
        end
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        ack_en = 1'b1;
        #3;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== c_RESET_PC || idone !== 1'b0) begin
            n_errors++;
            $display("FAIL areset_restart: got req=%b addr=%h done=%b expected 1 %h 0", mem_req, mem_addr, idone, c_RESET_PC);
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        stall       = 1'b0;
        ack_en      = 1'b0;
        force_ack   = 1'b0;
        err_en      = 1'b0;
        err_addr    = 16'h0;
        test_reset();
        test_fill();
        test_redirect_collision();
        test_fault();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
